// File: rtl/irq_controller_pkg.sv
// Shared definitions for the interrupt controller: register map and FSM encoding.
package irq_controller_pkg;

   localparam int MAX_SRC = 8;

   typedef logic [1:0] ioAddr_t;

   localparam ioAddr_t ADDR_ENABLE  = 2'd0;
   localparam ioAddr_t ADDR_PENDING = 2'd1;
   localparam ioAddr_t ADDR_ACTIVE  = 2'd2;
   localparam ioAddr_t ADDR_CTRL    = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } irqState_t;

endpackage

// File: rtl/irq_controller_if.sv
// Register bus plus CPU interrupt handshake between a CPU and irq_controller.
interface irq_controller_if;
   import irq_controller_pkg::*;

   ioAddr_t     io_addr;
   logic [7:0]  io_wdata;
   logic        io_we;
   logic        io_re;
   logic [7:0]  io_rdata;
   logic        irq;
   logic [2:0]  irq_id;
   logic        irq_clr;

   modport master (
      output io_addr, io_wdata, io_we, io_re, irq_clr,
      input  io_rdata, irq, irq_id
   );

   modport slave (
      input  io_addr, io_wdata, io_we, io_re, irq_clr,
      output io_rdata, irq, irq_id
   );
endinterface

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index-wins priority encoder with a valid flag.
module irq_prio_enc #(
   parameter int N = 8
) (
   input  logic [N-1:0] req,
   output logic [2:0]   idx,
   output logic         valid
);

   // Scan from the top so the lowest set bit is the last one written.
   always_comb begin
      idx   = '0;
      valid = |req;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) idx = 3'(i);
      end
   end

endmodule

// File: rtl/irq_controller.sv
// Edge-triggered interrupt controller: pending/enable registers, global enable,
// lowest-index arbitration and a REQ/HOLD handshake with the CPU.
module irq_controller
   import irq_controller_pkg::*;
#(
   parameter int NUM_SRC = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] src,
   irq_controller_if.slave    bus
);

   irqState_t          state, stateNext;
   logic [NUM_SRC-1:0] srcDly, enable, pending;
   logic [NUM_SRC-1:0] enableNext, pendingNext, srcEdge, w1cMask, ackClr, idOneHot;
   logic [NUM_SRC-1:0] candidate, candNext;
   logic               gie, gieNext, armed;
   logic [2:0]         irqId, encIdx;
   logic               encValid;
   logic               wrEnable, wrPending, wrCtrl;
   logic [7:0]         rdata, rdataNext;

   assign wrEnable  = bus.io_we && (bus.io_addr == ADDR_ENABLE);
   assign wrPending = bus.io_we && (bus.io_addr == ADDR_PENDING);
   assign wrCtrl    = bus.io_we && (bus.io_addr == ADDR_CTRL);

   // Edge detection is suppressed for the first cycle after reset so a line
   // already high at release is taken as history rather than a new event.
   always_comb begin
      srcEdge = src & ~srcDly & {NUM_SRC{armed}};
      for (int i = 0; i < NUM_SRC; i++) begin
         idOneHot[i] = (irqId == 3'(i));
         ackClr[i]   = (state == REQ) && bus.irq_clr && (irqId == 3'(i));
      end
      w1cMask     = wrPending ? bus.io_wdata[NUM_SRC-1:0] : '0;
      enableNext  = wrEnable ? bus.io_wdata[NUM_SRC-1:0] : enable;
      gieNext     = wrCtrl ? bus.io_wdata[0] : gie;
      pendingNext = (pending & ~(w1cMask | ackClr)) | srcEdge;
      candidate   = pending & enable & {NUM_SRC{gie}};
      candNext    = pendingNext & enableNext & {NUM_SRC{gieNext}};
   end

   irq_prio_enc #(.N(NUM_SRC)) prioEnc (
      .req   (candidate),
      .idx   (encIdx),
      .valid (encValid)
   );

   // Cancel looks at next-cycle candidates so a W1C, mask or GIE write drops
   // irq on the very next cycle.
   always_comb begin
      stateNext = state;
      case (state)
         IDLE: if (encValid) stateNext = REQ;
         REQ: begin
            if (bus.irq_clr)                   stateNext = HOLD;
            else if (!(|(candNext & idOneHot))) stateNext = IDLE;
         end
         HOLD:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         irqId   <= '0;
         srcDly  <= '0;
         armed   <= 1'b0;
         enable  <= '0;
         pending <= '0;
         gie     <= 1'b0;
      end else begin
         state   <= stateNext;
         srcDly  <= src;
         armed   <= 1'b1;
         enable  <= enableNext;
         pending <= pendingNext;
         gie     <= gieNext;
         if (state == IDLE && encValid) irqId <= encIdx;
      end
   end

   always_comb begin
      rdataNext = '0;
      case (bus.io_addr)
         ADDR_ENABLE:  rdataNext = 8'(enable);
         ADDR_PENDING: rdataNext = 8'(pending);
         ADDR_ACTIVE:  rdataNext = {bus.irq, 4'b0000, irqId};
         ADDR_CTRL:    rdataNext = {7'b0000000, gie};
         default:      rdataNext = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)          rdata <= '0;
      else if (bus.io_re)  rdata <= rdataNext;
   end

   assign bus.io_rdata = rdata;
   assign bus.irq      = (state == REQ);
   assign bus.irq_id   = irqId;

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 Parameter NUM_SRC, default 8, number of interrupt sources; range 1..8.
REQ-002 clk  input  1  system clock; all state SHALL change on its rising edge except on reset.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 src  input  NUM_SRC  peripheral event lines, synchronous to clk.
REQ-005 io_addr  input  2  register select: 0 ENABLE, 1 PENDING, 2 ACTIVE, 3 CTRL.
REQ-006 io_wdata  input  8  write data.
REQ-007 io_we  input  1  write strobe, one cycle per write.
REQ-008 io_re  input  1  read strobe.
REQ-009 io_rdata  output  8  read data.
REQ-010 irq  output  1  interrupt request to the CPU.
REQ-011 irq_id  output  3  index of the source behind irq.
REQ-012 irq_clr  input  1  CPU acknowledge pulse.

Function
REQ-013 Each source SHALL be rising-edge detected against a one-cycle-delayed copy; an edge SHALL set pending[i] at the next clock.
REQ-014 ENABLE (RW) SHALL mask sources; masked edges SHALL still set pending but SHALL NOT request.
REQ-015 PENDING write SHALL be write-1-to-clear; a bit set and cleared in the same cycle SHALL end set.
REQ-016 CTRL bit0 SHALL be the global enable (GIE); bits 7:1 SHALL read 0 and ignore writes.
REQ-017 ACTIVE (RO) SHALL read {irq, 4'b0, irq_id}; writes SHALL be ignored.
REQ-018 io_rdata SHALL be registered: valid one cycle after io_re, and hold its value otherwise.
REQ-019 Candidate set = pending & ENABLE & {NUM_SRC{GIE}}; lowest index SHALL win.
REQ-020 The FSM SHALL have states IDLE, REQ and HOLD.
REQ-021 In IDLE with a nonempty candidate set: latch the winner into irq_id and enter REQ.
REQ-022 In REQ, irq SHALL be 1 and irq_id SHALL be stable.
REQ-023 In REQ, irq_clr SHALL clear pending[irq_id] and enter HOLD.
REQ-024 In REQ, if the latched source leaves the candidate set before ack (W1C, mask, GIE=0), the FSM SHALL return to IDLE with irq=0; no pending bit SHALL be cleared by that cancel.
REQ-025 HOLD SHALL last exactly one cycle with irq=0, then enter IDLE.
REQ-026 The latency from a src edge to irq=1 SHALL be 2 cycles from IDLE: one cycle to set pending, one cycle to arbitrate.
REQ-027 An edge on the acknowledged source in the same cycle as irq_clr SHALL leave pending set.
REQ-028 irq_clr SHALL be ignored outside REQ.
REQ-029 A higher-priority arrival during REQ SHALL NOT preempt; it SHALL be served after HOLD.
REQ-030 Pending and enable bits at positions of NUM_SRC and above SHALL read 0.

Reset
REQ-031 While reset is low, the block SHALL hold ENABLE=0, PENDING=0, GIE=0, edge history=0, state=IDLE, irq=0, irq_id=0 and io_rdata=0.
REQ-032 Reset asserted during REQ SHALL drop irq immediately, without waiting for a clock edge.
REQ-033 After reset release, a src line that is already high SHALL NOT register an edge.

Structure
REQ-034 Register address constants and the FSM state encodings SHALL reside in the shared SoC package.
REQ-035 One sub-module, irq_prio_enc, SHALL provide a combinational lowest-index encoder with a valid output.

Verification
REQ-036 Scenario: ENABLE=0x04, GIE=1, pulse src[2] -> irq=1 and irq_id=2 two cycles later; irq_clr -> irq=0 for one cycle and PENDING=0x00.
REQ-037 Scenario: ENABLE=0xFF, GIE=1, src[5] and src[1] rise in the same cycle -> irq_id=1; after ack and HOLD -> irq_id=5.
REQ-038 Scenario: in REQ with id 3, write PENDING=0x08 -> irq=0 next cycle, FSM in IDLE, no ack needed.
REQ-039 Scenario: src[0] edge coincides with irq_clr for id 0 -> PENDING bit0=1 and irq reasserts after HOLD.
REQ-040 Scenario: GIE=0, pulse src[4] -> irq stays 0 and PENDING reads 0x10; set GIE=1 -> irq=1 with irq_id=4.
REQ-041 Scenario: pull reset low while irq=1 -> irq=0 at once; release with src held high -> PENDING stays 0x00.
